// File: rtl/spi_tx_seq.sv
// spi_tx_seq: FIFO-buffered word sequencer issuing one start pulse per word to an SPI writer,
// following its end-of-write handshake with an acceptance timeout and a post-frame idle gap.
module spi_tx_seq #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int GAP = 4,
  parameter int ACK_TO = 255,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             eow_i,
  output logic             str_o,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o,
  output logic             busy_o,
  output logic             ovf_o,
  output logic             err_o
);
  localparam int TW = $clog2(ACK_TO + 1);
  localparam int GW = $clog2(GAP + 2);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TO - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_ACK, S_DONE, S_GAP} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count;
  logic [WIDTH-1:0] r_data;
  logic [TW-1:0] r_to;
  logic [GW-1:0] r_gap;
  logic r_ovf, r_err;
  logic w_push, w_pop, w_to_hit, w_gap_done;
  // Full is judged on the registered count, so a same-cycle pop never rescues a write.
  assign full_o = r_count == FULL;
  assign empty_o = r_count == '0;
  assign count_o = r_count;
  assign data_o = r_data;
  assign ovf_o = r_ovf;
  assign err_o = r_err;
  assign w_push = wr_i && !full_o;
  assign w_to_hit = r_to == TO_LAST;
  assign w_gap_done = r_gap == GAP_LAST;
  always_ff @(posedge clk_i)
    if (w_push) r_mem[r_wptr] <= din_i;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      if (wr_i && full_o) r_ovf <= 1'b1;
    end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_count != '0) w_next = S_LOAD;
      S_LOAD:  w_next = S_START;
      S_START: w_next = S_ACK;
      S_ACK:   w_next = !eow_i ? S_DONE : w_to_hit ? S_IDLE : S_ACK;
      S_DONE:  if (eow_i) w_next = (GAP == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (w_gap_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    str_o = r_state == S_START;
    busy_o = r_state != S_IDLE || r_count != '0;
    w_pop = r_state == S_LOAD;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_data <= '0;
      r_to <= '0;
      r_gap <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_pop) r_data <= r_mem[r_rptr];
      r_to <= (r_state == S_ACK) ? r_to + 1'b1 : '0;
      r_gap <= (r_state == S_GAP) ? r_gap + 1'b1 : '0;
      if (r_state == S_ACK && eow_i && w_to_hit) r_err <= 1'b1;
    end
endmodule

// File: tb/tb_spi_tx_seq.sv
// tb_spi_tx_seq: directed checks of spi_tx_seq with default gap and a GAP=0 instance.
module tb_spi_tx_seq;
  logic clk = 1'b0, rst = 1'b1, wr = 1'b0, eow = 1'b1, sel = 1'b0;
  logic [15:0] din = '0;
  logic str, full, empty, busy, ovf, err, g_str, g_full, g_empty, g_busy, g_ovf, g_err;
  logic [15:0] data, g_data;
  logic [2:0] count, g_count;
  int checks = 0, errors = 0, n_str = 0, n_ffff = 0, n0, n;
  always #5 clk = ~clk;
  spi_tx_seq u_dut (.clk_i(clk), .rst_i(rst), .wr_i(wr), .din_i(din), .eow_i(eow),
    .str_o(str), .data_o(data), .full_o(full), .empty_o(empty), .count_o(count),
    .busy_o(busy), .ovf_o(ovf), .err_o(err));
  spi_tx_seq #(.GAP(0)) u_g0 (.clk_i(clk), .rst_i(rst), .wr_i(wr), .din_i(din), .eow_i(eow),
    .str_o(g_str), .data_o(g_data), .full_o(g_full), .empty_o(g_empty), .count_o(g_count),
    .busy_o(g_busy), .ovf_o(g_ovf), .err_o(g_err));
  wire str_s = sel ? g_str : str;
  wire [15:0] data_s = sel ? g_data : data;
  always @(negedge clk) begin
    if (str) n_str++;
    if (str && data == 16'hFFFF) n_ffff++;
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic next_frame(input string tag, input logic [15:0] w, input int gap,
                            input logic do_wr, input logic [15:0] wd);
    tick(); eow = 1'b0;
    tick(); wr = do_wr; din = wd;
    tick(); wr = 1'b0; eow = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!str_s && n < 40);
    chk({tag, "_gap"}, n, gap);
    chk({tag, "_data"}, data_s, w);
  endtask
  initial begin
    tick(); tick();
    chk("rst_str", str, 0); chk("rst_data", data, 0); chk("rst_full", full, 0);
    chk("rst_empty", empty, 1); chk("rst_count", count, 0); chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0); chk("rst_err", err, 0);
    rst = 1'b0;
    // single word: start two edges after the write
    tick(); wr = 1'b1; din = 16'hA5A5;
    tick(); wr = 1'b0; chk("t1_count1", count, 1); chk("t1_empty", empty, 0); chk("t1_str_e0", str, 0);
    tick(); chk("t1_str_e1", str, 0); chk("t1_busy", busy, 1);
    tick(); chk("t1_str_e2", str, 1); chk("t1_data", data, 16'hA5A5); chk("t1_count0", count, 0);
    tick(); chk("t1_str_e3", str, 0);
    tick(); eow = 1'b0;
    repeat (32) tick();
    eow = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(); chk("t1_busy_gap", busy, 1); end
    tick(); chk("t1_busy_end", busy, 0);
    chk("t1_nstr", n_str, 1);
    // burst into a busy sequencer, then a write dropped while in LOAD
    tick(); wr = 1'b1; din = 16'h1234;
    tick(); wr = 1'b0;
    tick();
    tick(); chk("t2_lead_str", str, 1); chk("t2_lead_data", data, 16'h1234);
    tick(); eow = 1'b0;
    tick(); wr = 1'b1; din = 16'h0001;
    tick(); din = 16'h0002;
    tick(); din = 16'h0003;
    tick(); din = 16'h0004;
    tick(); wr = 1'b0;
    chk("t2_full", full, 1); chk("t2_count4", count, 4); chk("t2_ovf0", ovf, 0);
    eow = 1'b1;
    repeat (5) tick();
    chk("t2_idle_str", str, 0);
    tick(); chk("t2_load_count", count, 4); chk("t2_load_full", full, 1);
    wr = 1'b1; din = 16'hFFFF;
    tick(); wr = 1'b0;
    chk("t2_ovf1", ovf, 1); chk("t2_count3", count, 3); chk("t2_full0", full, 0);
    chk("t2_w1_str", str, 1); chk("t2_w1_data", data, 16'h0001);
    next_frame("t2_w2", 16'h0002, 7, 1'b0, 16'h0);
    next_frame("t2_w3", 16'h0003, 7, 1'b0, 16'h0);
    next_frame("t2_w4", 16'h0004, 7, 1'b0, 16'h0);
    tick(); eow = 1'b0;
    tick();
    tick(); eow = 1'b1;
    repeat (8) tick();
    chk("t2_busy_end", busy, 0); chk("t2_empty", empty, 1);
    chk("t2_nstr", n_str, 6); chk("t2_no_ffff", n_ffff, 0);
    // acceptance timeout with eow held high
    n0 = n_str;
    wr = 1'b1; din = 16'h0BAD;
    tick(); wr = 1'b0;
    tick();
    tick(); chk("t3_str", str, 1); chk("t3_data", data, 16'h0BAD);
    tick();
    repeat (254) tick();
    chk("t3_err_early", err, 0); chk("t3_busy_wait", busy, 1);
    tick(); chk("t3_err", err, 1); chk("t3_busy_idle", busy, 0);
    repeat (10) tick();
    chk("t3_no_reissue", n_str, n0 + 1);
    // reset while in DONE with two words queued
    wr = 1'b1; din = 16'h0C01;
    tick(); wr = 1'b0;
    tick();
    tick(); chk("t5_str", str, 1);
    tick(); eow = 1'b0;
    tick(); wr = 1'b1; din = 16'h0C02;
    tick(); din = 16'h0C03;
    tick(); wr = 1'b0;
    chk("t5_count2", count, 2); chk("t5_ovf_pre", ovf, 1); chk("t5_err_pre", err, 1);
    n0 = n_str;
    #2 rst = 1'b1;
    #1;
    chk("t5_str", str, 0); chk("t5_count", count, 0); chk("t5_empty", empty, 1);
    chk("t5_busy", busy, 0); chk("t5_ovf", ovf, 0); chk("t5_err", err, 0);
    tick(); rst = 1'b0; eow = 1'b1;
    repeat (10) tick();
    chk("t5_no_start", n_str, n0);
    // GAP=0 instance: three-cycle restart and pointer wrap over ten words
    rst = 1'b1;
    tick(); rst = 1'b0; sel = 1'b1;
    chk("t6_rst_count", g_count, 0);
    wr = 1'b1; din = 16'h5A00;
    tick(); din = 16'h5A01;
    tick(); din = 16'h5A02;
    tick(); wr = 1'b0;
    chk("t6_w0_str", g_str, 1); chk("t6_w0_data", g_data, 16'h5A00); chk("t6_count", g_count, 2);
    for (int k = 1; k < 10; k++)
      next_frame("t6_w", 16'h5A00 + 16'(k), 3, k + 2 < 10, 16'h5A00 + 16'(k + 2));
    tick(); eow = 1'b0;
    tick();
    tick(); eow = 1'b1;
    repeat (3) tick();
    chk("t6_busy_end", g_busy, 0); chk("t6_empty", g_empty, 1);
    chk("t6_ovf", g_ovf, 0); chk("t6_err", g_err, 0); chk("t6_full", g_full, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
